// File: rtl/round_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : round_sequencer_if
//  Description : Control bundle between the round sequencer and the
//                matrix-encoder datapath / host. The master side is the
//                sequencer; the slave side is the datapath plus host.
//  Revision    : 1.0  initial release
// ============================================================================
interface round_sequencer_if #(
  parameter int ADDR_W = 6
);
  // host request / stage completion flags
  logic              start;
  logic              abort;
  logic              done1;
  logic              done2;
  logic              done3;
  logic              done4;
  logic              done5;
  // memory and datapath control
  logic [ADDR_W-1:0] mem_addr;
  logic              inreg_en;
  logic              wr_en;
  logic              cnt_rst_24;
  logic              cnt_en_24;
  logic              colParity_en;
  logic              rotate_en;
  logic              permute_en;
  logic              revalute_en;
  logic              addRC_en;
  // status
  logic [4:0]        round;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    input  start, abort, done1, done2, done3, done4, done5,
    output mem_addr, inreg_en, wr_en, cnt_rst_24, cnt_en_24,
           colParity_en, rotate_en, permute_en, revalute_en, addRC_en,
           round, busy, done, err
  );

  modport slave (
    output start, abort, done1, done2, done3, done4, done5,
    input  mem_addr, inreg_en, wr_en, cnt_rst_24, cnt_en_24,
           colParity_en, rotate_en, permute_en, revalute_en, addRC_en,
           round, busy, done, err
  );
endinterface
`default_nettype wire

// File: rtl/round_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : round_sequencer
//  Description : Top-level FSM for the matrix-encoder datapath. Loads
//                NUM_LINES lines, runs NUM_ROUNDS rounds of
//                colParity -> rotate -> permute -> revaluate -> addRC with a
//                start-pulse / done-flag handshake per stage, then writes
//                NUM_LINES result lines back out.
//  Revision    : 1.0  initial release
// ============================================================================
module round_sequencer #(
  parameter int NUM_ROUNDS = 24,
  parameter int NUM_LINES  = 64,
  parameter int TIMEOUT    = 1023,
  parameter int SKIP_REVAL = 0
) (
  input  logic               clk,
  input  logic               rst,
  round_sequencer_if.master  bus
);

  localparam int ADDR_W = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
  localparam int TMO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [ADDR_W-1:0] c_last_line  = ADDR_W'(NUM_LINES - 1);
  localparam logic [4:0]        c_last_round = 5'(NUM_ROUNDS - 1);
  // The counter value seen in the last cycle a stage may still complete.
  localparam logic [TMO_W-1:0]  c_tmo_last   = TMO_W'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_LOAD    = 4'd1,
    S_COLP    = 4'd2,
    S_ROT     = 4'd3,
    S_PERM    = 4'd4,
    S_REVAL   = 4'd5,
    S_ADDRC   = 4'd6,
    S_RND_END = 4'd7,
    S_WRITE   = 4'd8,
    S_DONE    = 4'd9,
    S_ERR     = 4'd10
  } state_t;

  // registered state
  state_t            r_state;
  logic [ADDR_W-1:0] r_line;
  logic [4:0]        r_round;
  logic [TMO_W-1:0]  r_tmo;
  logic              r_err;

  // next-state values
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] w_line_nxt;
  logic [4:0]        w_round_nxt;
  logic [TMO_W-1:0]  w_tmo_nxt;
  logic              w_err_nxt;

  // stage handshake helpers
  state_t            w_after_perm;
  state_t            w_stage_next;
  logic              w_in_stage;
  logic              w_stage_done;
  logic              w_first;

  // combinational outputs
  logic              w_inreg_en;
  logic              w_wr_en;
  logic              w_cnt_rst;
  logic              w_cnt_en;
  logic              w_colp_en;
  logic              w_rot_en;
  logic              w_perm_en;
  logic              w_reval_en;
  logic              w_addrc_en;
  logic              w_done;

  // The revaluate stage is either part of the round or skipped entirely.
  generate
    if (SKIP_REVAL != 0) begin : g_skip_reval
      assign w_after_perm = S_ADDRC;
    end else begin : g_with_reval
      assign w_after_perm = S_REVAL;
    end
  endgenerate

  // The timeout counter is cleared on every state entry, so a zero count
  // marks the first cycle of a stage: pulse the start, ignore done.
  assign w_first = (r_tmo == '0);

  // Next-state, counter and output decode; abort overrides everything last.
  always_comb begin
    w_state_nxt  = r_state;
    w_line_nxt   = r_line;
    w_round_nxt  = r_round;
    w_tmo_nxt    = '0;
    w_err_nxt    = r_err;
    w_inreg_en   = 1'b0;
    w_wr_en      = 1'b0;
    w_cnt_rst    = 1'b0;
    w_cnt_en     = 1'b0;
    w_colp_en    = 1'b0;
    w_rot_en     = 1'b0;
    w_perm_en    = 1'b0;
    w_reval_en   = 1'b0;
    w_addrc_en   = 1'b0;
    w_done       = 1'b0;
    w_in_stage   = 1'b0;
    w_stage_done = 1'b0;
    w_stage_next = S_IDLE;

    case (r_state)
      S_IDLE, S_ERR: begin
        if (bus.start) begin
          w_cnt_rst   = 1'b1;
          w_err_nxt   = 1'b0;
          w_round_nxt = '0;
          w_line_nxt  = '0;
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        w_inreg_en = 1'b1;
        if (r_line == c_last_line) begin
          w_line_nxt  = '0;
          w_state_nxt = S_COLP;
        end else begin
          w_line_nxt = r_line + ADDR_W'(1);
        end
      end
      S_COLP: begin
        w_in_stage   = 1'b1;
        w_colp_en    = w_first;
        w_stage_done = bus.done1;
        w_stage_next = S_ROT;
      end
      S_ROT: begin
        w_in_stage   = 1'b1;
        w_rot_en     = w_first;
        w_stage_done = bus.done2;
        w_stage_next = S_PERM;
      end
      S_PERM: begin
        w_in_stage   = 1'b1;
        w_perm_en    = w_first;
        w_stage_done = bus.done3;
        w_stage_next = w_after_perm;
      end
      S_REVAL: begin
        w_in_stage   = 1'b1;
        w_reval_en   = w_first;
        w_stage_done = bus.done4;
        w_stage_next = S_ADDRC;
      end
      S_ADDRC: begin
        w_in_stage   = 1'b1;
        w_addrc_en   = w_first;
        w_stage_done = bus.done5;
        w_stage_next = S_RND_END;
      end
      S_RND_END: begin
        w_cnt_en = 1'b1;
        if (r_round == c_last_round) begin
          w_line_nxt  = '0;
          w_state_nxt = S_WRITE;
        end else begin
          w_round_nxt = r_round + 5'd1;
          w_state_nxt = S_COLP;
        end
      end
      S_WRITE: begin
        w_wr_en = 1'b1;
        if (r_line == c_last_line) begin
          w_line_nxt  = '0;
          w_state_nxt = S_DONE;
        end else begin
          w_line_nxt = r_line + ADDR_W'(1);
        end
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Common stage handshake: done wins over timeout in the same cycle.
    if (w_in_stage) begin
      if (!w_first && w_stage_done) begin
        w_state_nxt = w_stage_next;
      end else if (r_tmo == c_tmo_last) begin
        w_state_nxt = S_ERR;
        w_err_nxt   = 1'b1;
      end else begin
        w_tmo_nxt = r_tmo + TMO_W'(1);
      end
    end

    // Abort kills all enables in the abort cycle itself and keeps round/err.
    if (bus.abort) begin
      w_state_nxt = S_IDLE;
      w_line_nxt  = '0;
      w_round_nxt = r_round;
      w_tmo_nxt   = '0;
      w_err_nxt   = r_err;
      w_inreg_en  = 1'b0;
      w_wr_en     = 1'b0;
      w_cnt_rst   = 1'b0;
      w_cnt_en    = 1'b0;
      w_colp_en   = 1'b0;
      w_rot_en    = 1'b0;
      w_perm_en   = 1'b0;
      w_reval_en  = 1'b0;
      w_addrc_en  = 1'b0;
      w_done      = 1'b0;
    end
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_line  <= '0;
      r_round <= '0;
      r_tmo   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_line  <= w_line_nxt;
      r_round <= w_round_nxt;
      r_tmo   <= w_tmo_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Address is only meaningful while streaming lines in or out.
  assign bus.mem_addr     = (r_state == S_LOAD || r_state == S_WRITE) ? r_line : '0;
  assign bus.inreg_en     = w_inreg_en;
  assign bus.wr_en        = w_wr_en;
  assign bus.cnt_rst_24   = w_cnt_rst;
  assign bus.cnt_en_24    = w_cnt_en;
  assign bus.colParity_en = w_colp_en;
  assign bus.rotate_en    = w_rot_en;
  assign bus.permute_en   = w_perm_en;
  assign bus.revalute_en  = w_reval_en;
  assign bus.addRC_en     = w_addrc_en;
  assign bus.round        = r_round;
  assign bus.busy         = !(r_state == S_IDLE || r_state == S_DONE || r_state == S_ERR);
  assign bus.done         = w_done;
  assign bus.err          = r_err;

endmodule
`default_nettype wire
